plab5_mcore_sec_mem_responder: RTL and testbench
================================================

# plab5_mcore_sec_mem_responder

Memory-bank responder at the cache/memory end of the separated-payload memory network. It accepts one request at a time, with control and data arriving on separate fields plus a domain bit. It checks the request's domain against a fixed high-security address region, then performs the read or write on a local word array. It returns a response split the same way, with domain and fail bits, so it can drive the response-side network adapter directly.

## Interface
Parameters:
- p_mem_opaque_nbits, 8, opaque field width (o)
- p_mem_addr_nbits, 32, byte address width (a)
- p_mem_data_nbits, 32, word/data width (d); only full-word accesses
- p_num_words, 256, array depth; word index = addr[2 +: $clog2(p_num_words)]
- p_sec_base, 128, first word index of the high-domain region; indices >= p_sec_base are high (domain 1)

Ports:
- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-low; reset state applied on any posedge with reset==0
- req_msg_control  in  3+o+a+2  {type, opaque, addr, len}
- req_msg_data  in  d  write data
- req_domain  in  1  requester domain (0 low, 1 high)
- req_val  in  1  request valid
- req_rdy  out  1  request ready
- resp_msg_control  out  3+o+2  {type, opaque, len}
- resp_msg_data  out  d  read data, 0 for writes and failed accesses
- resp_domain  out  1  equals captured req_domain
- resp_fail  out  1  access denied
- resp_val  out  1  response valid
- resp_rdy  in  1  response ready

## Operation
- Type encodings: READ=0, WRITE=1, WRITE_INIT=2. Any other type is handled as READ with fail=1.
- States: IDLE, ACCESS, RESP.
- IDLE: req_rdy=1. On req_val&&req_rdy, capture control, data and domain into a request register, then go to ACCESS.
- ACCESS: req_rdy=0, resp_val=0.
  - Compute deny = (captured_domain==0) && (index >= p_sec_base) && (type != WRITE_INIT).
  - WRITE or WRITE_INIT with !deny writes the array at this posedge.
  - READ with !deny latches the array word into the response data register. A denied READ latches 0.
  - Go to RESP.
- RESP: resp_val=1. Outputs come from registers and are stable while resp_val=1 && resp_rdy=0.
  - On resp_rdy=1, go to IDLE.
- Response fields:
  - type and opaque echo the request.
  - len echoes the request (len ignored for the access itself).
  - domain = captured domain.
  - fail = deny.
- WRITE_INIT bypasses the domain check. It is the test/boot preload path.
- Address bits above the index and the low two bits are ignored; no out-of-range fail.
- Array contents are not reset.

## Timing
- Reset values: req_rdy=0 while reset==0; resp_val=0, resp_fail=0, resp_domain=0, resp_msg_control=0, resp_msg_data=0; state=IDLE. req_rdy=1 on the first cycle after reset deasserts.
- Latency: request accepted at edge N, resp_val high from cycle N+2. Minimum three cycles per transaction; no overlap.
- req_rdy is a function of state only and never depends on req_val.
- resp_val is never withdrawn before resp_rdy.
- Stalled response: resp_rdy held 0 keeps the block in RESP indefinitely with req_rdy=0.
- Reset during ACCESS: the array write is suppressed at that edge and the transaction is discarded.
- Reset during RESP: the response is dropped; resp_val=0 on the next cycle.

## Configuration
- SEC_MEM_CHECK_EN:
  - Defined: the domain check is active as described.
  - Undefined: deny is tied to 0. All domains access the whole array and resp_fail is always 0. The insecure build is used for baseline comparison.
  - State machine and timing are identical in both builds.

## Structure
- Shared package/header:
  - type encodings (READ/WRITE/WRITE_INIT)
  - control-field width macros
  - field offset constants for {type, opaque, addr, len} and {type, opaque, len}
  - These are shared with the network adapters.
- Sub-module plab5_mcore_sec_mem_array: synchronous-write, registered-read word array with write enable.
- FSM, request register, domain check and response register stay in the top module.

## Test plan
- Domain 1 WRITE 0xDEADBEEF to addr 0x200 (index 128), then domain 1 READ 0x200 -> response data 0xDEADBEEF, fail=0, domain=1, opaque echoed, resp_val exactly 2 cycles after accept.
- WRITE_INIT 0x12345678 at index 130 from domain 0, then domain 0 READ index 130 -> data 0, fail=1. Then domain 0 WRITE 0x0 at index 130 -> fail=1. Domain 1 READ -> 0x12345678 (write was blocked).
- Domain 0 WRITE/READ 0xA5A5A5A5 at index 5 -> fail=0, data returned 0xA5A5A5A5.
- Hold resp_rdy=0 for 10 cycles -> resp_val and all response fields stable, req_rdy=0 throughout. Release -> req_rdy=1 the next cycle.
- Assert reset (0) in ACCESS of a WRITE to index 7 holding 0x11 -> resp_val stays 0, later READ index 7 returns 0x11.
- Build without SEC_MEM_CHECK_EN: repeat scenario 2 -> domain 0 READ index 130 returns 0x12345678 with fail=0.

Source files
------------

// File: rtl/plab5_mcore_sec_mem_responder_pkg.sv
// Shared encodings and field layout for the separated-payload memory messages.
// Used by the secure memory responder and by the network adapters.
`ifndef PLAB5_MCORE_SEC_MEM_RESPONDER_PKG_SV
`define PLAB5_MCORE_SEC_MEM_RESPONDER_PKG_SV

`define PLAB5_MEM_REQ_CTRL_NBITS(o_, a_)  (3 + (o_) + (a_) + 2)
`define PLAB5_MEM_RESP_CTRL_NBITS(o_)     (3 + (o_) + 2)

package plab5_mcore_sec_mem_responder_pkg;

    localparam int unsigned MEM_TYPE_NBITS = 32'd3;
    localparam int unsigned MEM_LEN_NBITS  = 32'd2;

    typedef enum logic [2:0] {
        MEM_READ       = 3'd0,
        MEM_WRITE      = 3'd1,
        MEM_WRITE_INIT = 3'd2
    } mem_type_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } resp_state_e;

    // Request control is {type, opaque, addr, len}, len in the LSBs
    localparam int unsigned MEM_REQ_LEN_LSB  = 32'd0;
    localparam int unsigned MEM_REQ_ADDR_LSB = 32'd2;

    function automatic int unsigned mem_req_opaque_lsb(input int unsigned a_nbits);
        return MEM_REQ_ADDR_LSB + a_nbits;
    endfunction

    function automatic int unsigned mem_req_type_lsb(input int unsigned o_nbits,
                                                     input int unsigned a_nbits);
        return MEM_REQ_ADDR_LSB + a_nbits + o_nbits;
    endfunction

    // Response control is {type, opaque, len}
    localparam int unsigned MEM_RESP_LEN_LSB    = 32'd0;
    localparam int unsigned MEM_RESP_OPAQUE_LSB = 32'd2;

    function automatic int unsigned mem_resp_type_lsb(input int unsigned o_nbits);
        return MEM_RESP_OPAQUE_LSB + o_nbits;
    endfunction

endpackage

`endif

// File: rtl/plab5_mcore_sec_mem_array.sv
// Word array with synchronous write and a registered read port.
// The read register can be loaded with zero so it doubles as the response data register.
module plab5_mcore_sec_mem_array
    import plab5_mcore_sec_mem_responder_pkg::*;
#(
    parameter int unsigned p_data_nbits = 32'd32,
    parameter int unsigned p_num_words  = 32'd256,
    localparam int unsigned IDX_NBITS   = $clog2(p_num_words)
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en_i,
    input  logic [IDX_NBITS-1:0]    idx_i,
    input  logic [p_data_nbits-1:0] wr_data_i,
    input  logic                    rd_en_i,
    input  logic                    rd_zero_i,
    output logic [p_data_nbits-1:0] rd_data_o
);

    logic [p_data_nbits-1:0] mem_q [p_num_words];
    logic [p_data_nbits-1:0] rd_data_q;

    // Storage write port; contents intentionally survive reset
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[idx_i] <= wr_data_i;
        end
    end

    // Registered read, holds its value until the next load
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= rd_zero_i ? '0 : mem_q[idx_i];
        end else begin
            rd_data_q <= rd_data_q;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/plab5_mcore_sec_mem_responder.sv
// Secure memory-bank responder: one request at a time, IDLE -> ACCESS -> RESP.
// Build option SEC_MEM_CHECK_EN enables the high-domain region check; without it nothing is denied.
module plab5_mcore_sec_mem_responder
    import plab5_mcore_sec_mem_responder_pkg::*;
#(
    parameter int unsigned p_mem_opaque_nbits = 32'd8,
    parameter int unsigned p_mem_addr_nbits   = 32'd32,
    parameter int unsigned p_mem_data_nbits   = 32'd32,
    parameter int unsigned p_num_words        = 32'd256,
    parameter int unsigned p_sec_base         = 32'd128
)(
    input  logic                                                             clk,
    input  logic                                                             reset,
    input  logic [`PLAB5_MEM_REQ_CTRL_NBITS(p_mem_opaque_nbits, p_mem_addr_nbits)-1:0] req_msg_control,
    input  logic [p_mem_data_nbits-1:0]                                      req_msg_data,
    input  logic                                                             req_domain,
    input  logic                                                             req_val,
    output logic                                                             req_rdy,
    output logic [`PLAB5_MEM_RESP_CTRL_NBITS(p_mem_opaque_nbits)-1:0]         resp_msg_control,
    output logic [p_mem_data_nbits-1:0]                                      resp_msg_data,
    output logic                                                             resp_domain,
    output logic                                                             resp_fail,
    output logic                                                             resp_val,
    input  logic                                                             resp_rdy
);

    localparam int unsigned IDX_NBITS    = $clog2(p_num_words);
    localparam int unsigned RESP_NBITS   = `PLAB5_MEM_RESP_CTRL_NBITS(p_mem_opaque_nbits);
    localparam int unsigned REQ_TYPE_LSB = mem_req_type_lsb(p_mem_opaque_nbits, p_mem_addr_nbits);
    localparam int unsigned REQ_OPQ_LSB  = mem_req_opaque_lsb(p_mem_addr_nbits);
    localparam int unsigned REQ_IDX_LSB  = MEM_REQ_ADDR_LSB + 32'd2;
    localparam int unsigned REQ_ADDR_MSB = MEM_REQ_ADDR_LSB + p_mem_addr_nbits - 32'd1;

    resp_state_e state_q, state_d;

    logic [2:0]                      req_type_q;
    logic [p_mem_opaque_nbits-1:0]   req_opaque_q;
    logic [IDX_NBITS-1:0]            req_idx_q;
    logic [1:0]                      req_len_q;
    logic [p_mem_data_nbits-1:0]     req_data_q;
    logic                            req_domain_q;

    logic [RESP_NBITS-1:0]           resp_ctrl_q;
    logic                            resp_domain_q;
    logic                            resp_fail_q;

    logic idle_s, access_s, resp_val_s;
    logic is_write_s, bad_type_s, deny_s, fail_s;
    logic wr_en_s, rd_en_s;
    logic unused_addr_s;

    // Byte offset and address bits above the word index take no part in the access
    assign unused_addr_s = ^{req_msg_control[REQ_ADDR_MSB:REQ_IDX_LSB + IDX_NBITS],
                             req_msg_control[MEM_REQ_ADDR_LSB +: 2]};

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        state_d    = state_q;
        idle_s     = 1'b0;
        access_s   = 1'b0;
        resp_val_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                idle_s = 1'b1;
                if (req_val) begin
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                access_s = 1'b1;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                resp_val_s = 1'b1;
                if (resp_rdy) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request register, loaded on accept
    always_ff @(posedge clk) begin
        if (!reset) begin
            req_type_q   <= 3'd0;
            req_opaque_q <= '0;
            req_idx_q    <= '0;
            req_len_q    <= 2'd0;
            req_data_q   <= '0;
            req_domain_q <= 1'b0;
        end else if (idle_s && req_val) begin
            req_type_q   <= req_msg_control[REQ_TYPE_LSB +: MEM_TYPE_NBITS];
            req_opaque_q <= req_msg_control[REQ_OPQ_LSB +: p_mem_opaque_nbits];
            req_idx_q    <= req_msg_control[REQ_IDX_LSB +: IDX_NBITS];
            req_len_q    <= req_msg_control[MEM_REQ_LEN_LSB +: MEM_LEN_NBITS];
            req_data_q   <= req_msg_data;
            req_domain_q <= req_domain;
        end else begin
            req_type_q   <= req_type_q;
            req_opaque_q <= req_opaque_q;
            req_idx_q    <= req_idx_q;
            req_len_q    <= req_len_q;
            req_data_q   <= req_data_q;
            req_domain_q <= req_domain_q;
        end
    end

    // Request type decode; unknown types behave as a failed read
    always_comb begin
        is_write_s = 1'b0;
        bad_type_s = 1'b0;
        case (req_type_q)
            MEM_READ:                  is_write_s = 1'b0;
            MEM_WRITE, MEM_WRITE_INIT: is_write_s = 1'b1;
            default:                   bad_type_s = 1'b1;
        endcase
    end

`ifdef SEC_MEM_CHECK_EN
    localparam logic [IDX_NBITS-1:0] SEC_BASE_IDX = IDX_NBITS'(p_sec_base);
    // Low-domain requesters may not touch the high region except through the preload path
    assign deny_s = !req_domain_q && (req_idx_q >= SEC_BASE_IDX) &&
                    (req_type_q != MEM_WRITE_INIT);
`else
    assign deny_s = 1'b0;
`endif

    assign fail_s = deny_s || bad_type_s;

    // A reset arriving at the end of ACCESS must not commit the write
    assign wr_en_s = access_s && reset && is_write_s && !fail_s;
    assign rd_en_s = access_s;

    plab5_mcore_sec_mem_array #(
        .p_data_nbits (p_mem_data_nbits),
        .p_num_words  (p_num_words)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (wr_en_s),
        .idx_i     (req_idx_q),
        .wr_data_i (req_data_q),
        .rd_en_i   (rd_en_s),
        .rd_zero_i (is_write_s || fail_s),
        .rd_data_o (resp_msg_data)
    );

    // Response register, loaded at the end of ACCESS and held through RESP
    always_ff @(posedge clk) begin
        if (!reset) begin
            resp_ctrl_q   <= '0;
            resp_domain_q <= 1'b0;
            resp_fail_q   <= 1'b0;
        end else if (access_s) begin
            resp_ctrl_q   <= {req_type_q, req_opaque_q, req_len_q};
            resp_domain_q <= req_domain_q;
            resp_fail_q   <= fail_s;
        end else begin
            resp_ctrl_q   <= resp_ctrl_q;
            resp_domain_q <= resp_domain_q;
            resp_fail_q   <= resp_fail_q;
        end
    end

    assign req_rdy          = idle_s && reset;
    assign resp_val         = resp_val_s;
    assign resp_msg_control = resp_ctrl_q;
    assign resp_domain      = resp_domain_q;
    assign resp_fail        = resp_fail_q;

endmodule

// File: tb/tb_plab5_mcore_sec_mem_responder.sv
// Randomized self-checking bench for plab5_mcore_sec_mem_responder against a word-array reference model.
// Follows the SEC_MEM_CHECK_EN build option of the design.
module tb_plab5_mcore_sec_mem_responder;

    localparam int N_WORDS = 256;
    localparam int SEC_BASE = 128;
`ifdef SEC_MEM_CHECK_EN
    localparam bit SEC_EN = 1'b1;
`else
    localparam bit SEC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [44:0] req_msg_control = '0;
    logic [31:0] req_msg_data = '0;
    logic        req_domain = 1'b0;
    logic        req_val = 1'b0;
    logic        req_rdy;
    logic [12:0] resp_msg_control;
    logic [31:0] resp_msg_data;
    logic        resp_domain;
    logic        resp_fail;
    logic        resp_val;
    logic        resp_rdy = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [31:0] ref_mem [N_WORDS];

    always #5 clk = ~clk;

    plab5_mcore_sec_mem_responder dut (
        .clk              (clk),
        .reset            (reset),
        .req_msg_control  (req_msg_control),
        .req_msg_data     (req_msg_data),
        .req_domain       (req_domain),
        .req_val          (req_val),
        .req_rdy          (req_rdy),
        .resp_msg_control (resp_msg_control),
        .resp_msg_data    (resp_msg_data),
        .resp_domain      (resp_domain),
        .resp_fail        (resp_fail),
        .resp_val         (resp_val),
        .resp_rdy         (resp_rdy)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one access: returns expected fail flag and data, updates the model array
    task automatic ref_access(input logic [2:0] t, input logic [31:0] addr, input logic dom,
                              input logic [31:0] wdata, output logic exp_fail, output logic [31:0] exp_data);
        int idx;
        bit bad;
        bit deny;
        idx  = int'(addr[9:2]);
        bad  = (t > 3'd2);
        deny = SEC_EN && !dom && (idx >= SEC_BASE) && (t != 3'd2);
        exp_fail = bad || deny;
        exp_data = 32'd0;
        if (!exp_fail) begin
            if (t == 3'd0) exp_data = ref_mem[idx];
            else           ref_mem[idx] = wdata;
        end
    endtask

    // Present a request and wait until the next rising edge accepts it; returns 0 on timeout
    task automatic send_req(input logic [2:0] t, input logic [7:0] opq, input logic [31:0] addr,
                            input logic [1:0] len, input logic [31:0] wdata, input logic dom,
                            output bit ok);
        int waited;
        @(negedge clk);
        req_msg_control = {t, opq, addr, len};
        req_msg_data    = wdata;
        req_domain      = dom;
        req_val         = 1'b1;
        waited = 0;
        while (req_rdy !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        ok = (req_rdy === 1'b1);
        if (!ok) begin
            check_val("req_rdy_timeout", {63'd0, req_rdy}, 64'd1);
            req_val = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            req_val         = 1'b0;
            req_msg_control = {13'($urandom), $urandom};
            req_msg_data    = $urandom;
            req_domain      = 1'($urandom);
        end
    endtask

    task automatic do_txn(input logic [2:0] t, input logic [7:0] opq, input logic [31:0] addr,
                          input logic [1:0] len, input logic [31:0] wdata, input logic dom,
                          input int stall);
        bit ok;
        logic ef;
        logic [31:0] ed;
        logic [12:0] ectl;
        send_req(t, opq, addr, len, wdata, dom, ok);
        if (ok) begin
            ref_access(t, addr, dom, wdata, ef, ed);
            ectl = {t, opq, len};
            @(negedge clk);
            check_val("access_resp_val", {63'd0, resp_val}, 64'd0);
            check_val("access_req_rdy", {63'd0, req_rdy}, 64'd0);
            @(negedge clk);
            check_val("resp_val", {63'd0, resp_val}, 64'd1);
            check_val("resp_ctrl", {51'd0, resp_msg_control}, {51'd0, ectl});
            check_val("resp_data", {32'd0, resp_msg_data}, {32'd0, ed});
            check_val("resp_domain", {63'd0, resp_domain}, {63'd0, dom});
            check_val("resp_fail", {63'd0, resp_fail}, {63'd0, ef});
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check_val("stall_resp_val", {63'd0, resp_val}, 64'd1);
                check_val("stall_req_rdy", {63'd0, req_rdy}, 64'd0);
                check_val("stall_ctrl", {51'd0, resp_msg_control}, {51'd0, ectl});
                check_val("stall_data", {32'd0, resp_msg_data}, {32'd0, ed});
                check_val("stall_dom_fail", {62'd0, resp_domain, resp_fail}, {62'd0, dom, ef});
            end
            resp_rdy = 1'b1;
            @(negedge clk);
            resp_rdy = 1'b0;
            check_val("post_resp_req_rdy", {63'd0, req_rdy}, 64'd1);
            check_val("post_resp_val", {63'd0, resp_val}, 64'd0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_resp_val"}, {63'd0, resp_val}, 64'd0);
        check_val({tag, "_resp_ctrl"}, {51'd0, resp_msg_control}, 64'd0);
        check_val({tag, "_resp_data"}, {32'd0, resp_msg_data}, 64'd0);
        check_val({tag, "_resp_dom_fail"}, {62'd0, resp_domain, resp_fail}, 64'd0);
    endtask

    initial begin
        bit ok;
        logic [2:0] t;
        logic [31:0] addr;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_req_rdy", {63'd0, req_rdy}, 64'd0);
        check_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clk);
        check_val("post_reset_req_rdy", {63'd0, req_rdy}, 64'd1);

        // Preload every word through the boot path from random domains
        for (int i = 0; i < N_WORDS; i++) begin
            addr = {22'($urandom), 8'(i), 2'($urandom)};
            do_txn(3'd2, 8'($urandom), addr, 2'($urandom), $urandom, 1'($urandom), 0);
        end

        // High domain write/read in the secure region
        do_txn(3'd1, 8'h3c, 32'h0000_0200, 2'd0, 32'hDEAD_BEEF, 1'b1, 0);
        do_txn(3'd0, 8'h5a, 32'h0000_0200, 2'd1, 32'd0, 1'b1, 0);

        // Preload from low domain, then low-domain read/write attempts
        do_txn(3'd2, 8'h01, 32'h0000_0208, 2'd0, 32'h1234_5678, 1'b0, 0);
        do_txn(3'd0, 8'h02, 32'h0000_0208, 2'd2, 32'd0, 1'b0, 0);
        do_txn(3'd1, 8'h03, 32'h0000_0208, 2'd0, 32'h0000_0000, 1'b0, 0);
        do_txn(3'd0, 8'h04, 32'h0000_0208, 2'd3, 32'd0, 1'b1, 0);

        // Low domain in the open region
        do_txn(3'd1, 8'h10, 32'h0000_0014, 2'd0, 32'hA5A5_A5A5, 1'b0, 0);
        do_txn(3'd0, 8'h11, 32'h0000_0014, 2'd0, 32'd0, 1'b0, 0);

        // Long response stall
        do_txn(3'd0, 8'h77, 32'h0000_0200, 2'd1, 32'd0, 1'b1, 10);

        // Reset during ACCESS of a write: the write must not land
        do_txn(3'd2, 8'h20, 32'h0000_001C, 2'd0, 32'h0000_0011, 1'b0, 0);
        send_req(3'd1, 8'h21, 32'h0000_001C, 2'd0, 32'hFFFF_FFFF, 1'b0, ok);
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_access_resp_val", {63'd0, resp_val}, 64'd0);
        @(negedge clk);
        check_val("rst_access_req_rdy", {63'd0, req_rdy}, 64'd0);
        check_reset_outputs("rst_access");
        reset = 1'b1;
        @(negedge clk);
        check_val("rst_access_resume_rdy", {63'd0, req_rdy}, 64'd1);
        check_val("rst_access_resume_val", {63'd0, resp_val}, 64'd0);
        do_txn(3'd0, 8'h22, 32'h0000_001C, 2'd0, 32'd0, 1'b0, 0);

        // Reset during RESP drops the response
        send_req(3'd0, 8'h30, 32'h0000_0200, 2'd2, 32'd0, 1'b1, ok);
        @(negedge clk);
        @(negedge clk);
        check_val("rst_resp_pre_val", {63'd0, resp_val}, 64'd1);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_resp");
        reset = 1'b1;
        @(negedge clk);
        check_val("rst_resp_resume_rdy", {63'd0, req_rdy}, 64'd1);

        // Random traffic, occasionally with unknown types
        for (int n = 0; n < 300; n++) begin
            t = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            addr = $urandom;
            do_txn(t, 8'($urandom), addr, 2'($urandom), $urandom, 1'($urandom),
                   int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
